jt51_exp_arb: RTL
=================

// Module: jt51_exp_arb
// PURPOSE
//  Shares the single registered exponent ROM (32 x 45b, clk_en-gated read) among NREQ requesters.
//  Port 0 is the real-time operator pipeline: strict priority, never stalled.
//  Ports 1..NREQ-1 are background users (table readback, test/debug), served round-robin.
//  Fully pipelined: one ROM access per enabled cycle. Responses return tagged with the requester id.
// PARAMETERS
//  NREQ  4   requester count; port 0 real-time, 1..NREQ-1 round-robin (NREQ>=2)
//  AW    5   ROM address width
//  DW    45  ROM data width
//  IDW   2   requester id width, clog2(NREQ)
// PORTS
//  clk        in   1         system clock
//  rst_n      in   1         synchronous reset, active low
//  cen        in   1         clock enable; all state advances only when cen=1
//  req_valid  in   NREQ      per-port request valid
//  req_addr   in   NREQ*AW   per-port address; port i at [i*AW +: AW]
//  req_ready  out  NREQ      per-port accept (combinational)
//  rom_addr   out  AW        registered ROM address
//  rom_cen    out  1         ROM clk_en; equals cen
//  rom_data   in   DW        ROM registered output
//  rsp_valid  out  1         response valid; qualified by cen
//  rsp_id     out  IDW       id of the requester that owns rsp_data
//  rsp_data   out  DW        equals rom_data (wired through)
// BEHAVIOUR
//  - One clock (clk). Reset is synchronous and active-low (rst_n). While rst_n=0, every clk edge clears:
//    rom_addr=0, rsp_valid=0, rsp_id=0, stage-1 valid/id=0, rr_ptr=NREQ-1. req_ready=0 while rst_n=0.
//  - Handshake: a transfer occurs on port i when req_valid[i]&req_ready[i] at a clk edge.
//    Requester holds valid and addr stable until accepted. A requester may drop valid before acceptance.
//  - Arbitration, combinational, same cycle:
//    - req_ready[0] = cen & rst_n.
//    - For i>0: req_ready[i] = cen & rst_n & ~req_valid[0] & (i==rr_winner).
//    - rr_winner is the first valid port scanning rr_ptr+1, rr_ptr+2, ..., wrapping within 1..NREQ-1 (0 skipped).
//  - rr_ptr updates to i only when port i>0 transfers. Otherwise it holds, including on port-0 grants.
//  - Port 0 valid every cycle starves ports 1..NREQ-1 indefinitely. This is by design; no starvation guard.
//  - Pipeline, counting only cen=1 edges. Handshake at edge E0:
//    - E0: rom_addr<=granted addr; s1_valid<=1; s1_id<=i.
//    - E1: the ROM captures data.
//    - E1: rsp_valid<=s1_valid; rsp_id<=s1_id.
//    - After E1: rsp_data is valid.
//    - Latency is 2 enabled cycles. Throughput is 1 per enabled cycle. No back-pressure on responses.
//  - No grant at an enabled edge: rom_addr holds and s1_valid<=0.
//  - cen=0: no handshakes; all registers hold; rom_cen=0, so the ROM holds too. rsp_data stays consistent.
//    A response is consumed once, at the first cen=1 edge where rsp_valid=1.
//  - Reset mid-operation: in-flight requests are dropped with no response. After release, the first round-robin search starts at port 1.
//  - Widths: addresses pass unmodified; ids are zero-extended port indices.
// STRUCTURE
//  - Package jt51_exp_pkg: EXP_AW=5, EXP_DW=45, RT_PORT=0, and the id-width function.
//  - Sub-module jt51_exp_rr: round-robin picker. Inputs: valid vector and ptr. Outputs: one-hot winner and index. Purely combinational.
//  - Top module holds the ptr, stage-1/response registers and port-0 override.
//  - ROM is instantiated by the parent: rom_addr->addr, rom_cen->clk_en.
// TESTING
//  1. cen=1. Port1 valid, addr=5, for one cycle.
//     -> req_ready[1]=1 that cycle; rsp_valid=1, rsp_id=1, rsp_data=ROM[5] two cycles later.
//  2. Port0 addr=3 and port2 addr=7 both valid.
//     -> req_ready[0]=1, req_ready[2]=0. Drop port0 next cycle -> port2 granted. Responses id0/ROM[3] then id2/ROM[7].
//  3. Ports1,2,3 held valid for 6 cycles.
//     -> grant order 1,2,3,1,2,3; rsp_valid high 6 consecutive cycles starting 2 cycles after the first grant.
//  4. cen pattern 1,0,0,1,1 with port1 addr=9 valid from start.
//     -> accept at the 1st cycle only; rsp_valid seen at the 5th cycle (2nd following enabled edge), data ROM[9].
//  5. Two requests in flight, then rst_n=0 for 1 cycle.
//     -> no rsp_valid afterwards for them. Ports1,3 valid after release -> port1 granted first.
//  6. Port0 valid for 10 cycles with port1 valid.
//     -> req_ready[1]=0 throughout; 10 responses id0; port1 granted the cycle port0 drops.

Source files
------------

// File: rtl/jt51_exp_pkg.sv
// Shared constants and helpers for the exponent-ROM arbiter.
package jt51_exp_pkg;

    localparam int EXP_AW  = 5;
    localparam int EXP_DW  = 45;
    localparam int RT_PORT = 0;

    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/jt51_exp_arb_if.sv
// Request/response bundle between the exponent-ROM requesters and the arbiter.
interface jt51_exp_arb_if
    import jt51_exp_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int AW   = EXP_AW,
    parameter int DW   = EXP_DW,
    parameter int IDW  = id_width(NREQ)
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ-1:0]    req_ready;
    logic               rsp_valid;
    logic [IDW-1:0]     rsp_id;
    logic [DW-1:0]      rsp_data;

    modport master (output req_valid, req_addr, input req_ready, rsp_valid, rsp_id, rsp_data);
    modport slave  (input req_valid, req_addr, output req_ready, rsp_valid, rsp_id, rsp_data);
endinterface

// File: rtl/jt51_exp_rr.sv
// Round-robin picker over the background ports 1..NREQ-1; port 0 never takes part.
module jt51_exp_rr
    import jt51_exp_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = id_width(NREQ)
) (
    input  logic [NREQ-1:1] valid,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] onehot,
    output logic [IDW-1:0]  idx,
    output logic            any
);
    localparam int NBG = NREQ - 1;

    // The winner is the valid port at the smallest distance after ptr, wrapping within 1..NREQ-1.
    always_comb begin
        int best_j;
        int best_d;
        int d;
        // NOTE: every output and temporary gets a value before any branch, so no latch is inferred.
        best_j = 0;
        best_d = NBG;
        d      = 0;
        onehot = '0;
        for (int j = 1; j < NREQ; j++) begin
            d = (j - int'(ptr) - 1 + 2 * NBG) % NBG;
            if (valid[j] && d < best_d) begin
                best_d = d;
                best_j = j;
            end
        end
        any = (best_j != 0);
        for (int j = 1; j < NREQ; j++) begin
            onehot[j] = (best_j == j);
        end
        idx = IDW'(best_j);
    end

endmodule

// File: rtl/jt51_exp_arb.sv
// Exponent-ROM arbiter: port 0 has strict priority, ports 1..NREQ-1 share the rest
// round-robin; two enabled cycles from grant to tagged response.
module jt51_exp_arb
    import jt51_exp_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int AW   = EXP_AW,
    parameter int DW   = EXP_DW,
    parameter int IDW  = id_width(NREQ)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cen,
    jt51_exp_arb_if.slave bus,
    output logic [AW-1:0] rom_addr,
    output logic          rom_cen,
    input  logic [DW-1:0] rom_data
);
    logic [IDW-1:0]  rr_ptr, rr_idx;
    logic [NREQ-1:0] rr_onehot;
    logic            rr_any;
    logic            live, rt_fire, bg_fire;
    logic [AW-1:0]   bg_addr;
    logic            s1_valid, rsp_valid_q;
    logic [IDW-1:0]  s1_id, rsp_id_q;

    jt51_exp_rr #(.NREQ(NREQ), .IDW(IDW)) u_rr (
        .valid  (bus.req_valid[NREQ-1:1]),
        .ptr    (rr_ptr),
        .onehot (rr_onehot),
        .idx    (rr_idx),
        .any    (rr_any)
    );

    assign live    = cen & rst_n;
    assign rt_fire = live & bus.req_valid[RT_PORT];
    assign bg_fire = live & ~bus.req_valid[RT_PORT] & rr_any;

    always_comb begin
        bus.req_ready          = rr_onehot & {NREQ{live & ~bus.req_valid[RT_PORT]}};
        bus.req_ready[RT_PORT] = live;
    end

    always_comb begin
        bg_addr = '0;
        for (int j = 1; j < NREQ; j++) begin
            if (rr_idx == IDW'(j)) bg_addr = bus.req_addr[j*AW +: AW];
        end
    end

    // rr_ptr resets to the last port so the first search after reset starts at port 1.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            rom_addr    <= '0;
            s1_valid    <= 1'b0;
            s1_id       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rr_ptr      <= IDW'(NREQ - 1);
        end else if (cen) begin
            rsp_valid_q <= s1_valid;
            rsp_id_q    <= s1_id;
            if (rt_fire) begin
                rom_addr <= bus.req_addr[RT_PORT*AW +: AW];
                s1_valid <= 1'b1;
                s1_id    <= IDW'(RT_PORT);
            end else if (bg_fire) begin
                rom_addr <= bg_addr;
                s1_valid <= 1'b1;
                s1_id    <= rr_idx;
                rr_ptr   <= rr_idx;
            end else begin
                s1_valid <= 1'b0;
            end
        end
    end

    assign rom_cen       = cen;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rom_data;

endmodule
